useq_run_ctrl: RTL and testbench

- Run/halt/step controller for the KS-10 microsequencer.
- Owns the `clken` and synchronous CPU reset that feed the microsequencer and CROM.
- Sequences power-on reset, free-run, counted single-step and microcode-address breakpoints under console command.
- Sits between the console interface and the CPU core; counts executed microinstructions for diagnostics.

---
 rtl/useq_ctrl_pkg.sv | 39 +++
 rtl/useq_run_ctrl_if.sv | 36 +++
 rtl/useq_prescale.sv | 38 +++
 rtl/useq_run_ctrl.sv | 125 ++++++++++++
 tb/tb_useq_run_ctrl.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/useq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// useq_ctrl_pkg
// Shared types and constants for the KS-10 microsequencer run/halt/step
// controller.
//   ctrlState_t    - controller states
//   consCmd_t      - console command after same-cycle priority resolution
//   uAddr_t        - 12-bit CROM microaddress
//   PAGE_FAIL_ADDR - page-fail microcode entry point (o3777)
// ---------------------------------------------------------------------------
package useq_ctrl_pkg;

  typedef enum logic [1:0] {
    RESET = 2'd0,
    HALT  = 2'd1,
    RUN   = 2'd2,
    STEP  = 2'd3
  } ctrlState_t;

  // Encoded so that a larger value wins when commands collide.
  typedef enum logic [1:0] {
    CMD_NONE = 2'd0,
    CMD_RUN  = 2'd1,
    CMD_STEP = 2'd2,
    CMD_HALT = 2'd3
  } consCmd_t;

  typedef logic [11:0] uAddr_t;

  localparam uAddr_t PAGE_FAIL_ADDR = 12'o3777;

  // Halt beats step beats run.
  function automatic consCmd_t resolveCmd(input logic run, input logic halt, input logic step);
    if (halt) return CMD_HALT;
    if (step) return CMD_STEP;
    if (run)  return CMD_RUN;
    return CMD_NONE;
  endfunction

endpackage

// File: rtl/useq_run_ctrl_if.sv
// ---------------------------------------------------------------------------
// useq_run_ctrl_if
// Console/CPU-facing bundle of the run controller.
//   slave  : controller side (commands, step count, breakpoint and current
//            microaddress in; cpuRST/clken/halted/brkHIT/cycCOUNT out)
//   master : console / CPU side (the mirror image)
// ---------------------------------------------------------------------------
interface useq_run_ctrl_if #(
  parameter int CNTW = 36
) ();
  import useq_ctrl_pkg::*;

  logic            cmdRUN;
  logic            cmdHALT;
  logic            cmdSTEP;
  logic [15:0]     stepCNT;
  logic            brkEN;
  uAddr_t          brkADDR;
  uAddr_t          uADDR;
  logic            cpuRST;
  logic            clken;
  logic            halted;
  logic            brkHIT;
  logic [CNTW-1:0] cycCOUNT;

  modport slave (
    input  cmdRUN, cmdHALT, cmdSTEP, stepCNT, brkEN, brkADDR, uADDR,
    output cpuRST, clken, halted, brkHIT, cycCOUNT
  );

  modport master (
    output cmdRUN, cmdHALT, cmdSTEP, stepCNT, brkEN, brkADDR, uADDR,
    input  cpuRST, clken, halted, brkHIT, cycCOUNT
  );

endinterface

// File: rtl/useq_prescale.sv
// ---------------------------------------------------------------------------
// useq_prescale
// Tick generator for the microsequencer clock enable: tick is high once every
// CLKDIV cycles while clr is low. clr holds the count at zero, so the first
// tick after clr drops comes CLKDIV-1 cycles later (immediately for CLKDIV=1).
//   clk, rst : clock, asynchronous active-low reset
//   clr      : synchronous clear / hold
//   tick     : prescaler at terminal count this cycle
// ---------------------------------------------------------------------------
module useq_prescale #(
  parameter int CLKDIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int PW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLKDIV - 1);

  logic [PW-1:0] count;

  assign tick = !clr && (count == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr || tick) begin
      count <= '0;
    end else begin
      count <= count + PW'(1);
    end
  end

endmodule

// File: rtl/useq_run_ctrl.sv
// ---------------------------------------------------------------------------
// useq_run_ctrl
// Run/halt/step controller for the KS-10 microsequencer. Generates the
// microsequencer clock enable and the synchronous CPU reset, and sequences
// power-on reset, free run, counted single-step and microaddress breakpoints.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : useq_run_ctrl_if.slave
//              in : cmdRUN, cmdHALT, cmdSTEP, stepCNT, brkEN, brkADDR, uADDR
//              out: cpuRST, clken, halted, brkHIT, cycCOUNT (all registered)
// A clken decision is made in the cycle before the pulse is visible; the
// breakpoint compare uses uADDR in that decision cycle.
// ---------------------------------------------------------------------------
module useq_run_ctrl
  import useq_ctrl_pkg::*;
#(
  parameter int RST_CYCLES = 4,
  parameter int CLKDIV     = 1,
  parameter int CNTW       = 36
) (
  input  logic             clk,
  input  logic             rst,
  useq_run_ctrl_if.slave   bus
);

  localparam int RCW = $clog2(RST_CYCLES + 1);

  ctrlState_t      state;
  logic            cpuRst;
  logic            clkEn;
  logic            halted;
  logic            brkHit;
  logic [CNTW-1:0] cycCount;
  logic [15:0]     stepCtr;
  logic [RCW-1:0]  rstCtr;
  logic            brkMask;   // skip the compare for the first pulse after HALT
  logic            tick;
  logic            brkMatch;
  consCmd_t        cmd;

  useq_prescale #(.CLKDIV(CLKDIV)) uPrescale (
    .clk  (clk),
    .rst  (rst),
    .clr  (!(state == RUN || state == STEP)),
    .tick (tick)
  );

  assign cmd      = resolveCmd(bus.cmdRUN, bus.cmdHALT, bus.cmdSTEP);
  assign brkMatch = bus.brkEN && (bus.uADDR == bus.brkADDR) && !brkMask;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RESET;
      cpuRst   <= 1'b1;
      clkEn    <= 1'b0;
      halted   <= 1'b0;
      brkHit   <= 1'b0;
      cycCount <= '0;
      stepCtr  <= '0;
      rstCtr   <= '0;
      brkMask  <= 1'b0;
    end else begin
      clkEn <= 1'b0;
      unique case (state)
        // Clock address o0000 repeatedly under cpuRST, then drop it.
        RESET: begin
          if (rstCtr == RCW'(RST_CYCLES)) begin
            cpuRst <= 1'b0;
            halted <= 1'b1;
            state  <= HALT;
          end else begin
            clkEn  <= 1'b1;
            rstCtr <= rstCtr + RCW'(1);
          end
        end

        HALT: begin
          unique case (cmd)
            CMD_STEP: begin
              state   <= STEP;
              halted  <= 1'b0;
              brkHit  <= 1'b0;
              brkMask <= 1'b1;
              stepCtr <= (bus.stepCNT == 16'd0) ? 16'd1 : bus.stepCNT;
            end
            CMD_RUN: begin
              state   <= RUN;
              halted  <= 1'b0;
              brkHit  <= 1'b0;
              brkMask <= 1'b1;
            end
            default: ;
          endcase
        end

        RUN, STEP: begin
          if (tick && brkMatch) begin
            // Suppress the pulse so the breakpointed word has not executed.
            state  <= HALT;
            halted <= 1'b1;
            brkHit <= 1'b1;
          end else begin
            if (tick) begin
              clkEn    <= 1'b1;
              cycCount <= cycCount + CNTW'(1);
              brkMask  <= 1'b0;
              if (state == STEP) stepCtr <= stepCtr - 16'd1;
            end
            // A halt command still lets this cycle's pulse fire.
            if (bus.cmdHALT || (state == STEP && tick && stepCtr == 16'd1)) begin
              state  <= HALT;
              halted <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign bus.cpuRST   = cpuRst;
  assign bus.clken    = clkEn;
  assign bus.halted   = halted;
  assign bus.brkHIT   = brkHit;
  assign bus.cycCOUNT = cycCount;

endmodule

// File: tb/tb_useq_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_useq_run_ctrl
// Directed bench for useq_run_ctrl. Two instances share the same stimulus:
// dut1 with CLKDIV=1 and dut3 with CLKDIV=3. Inputs change just after the
// falling edge and outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_useq_run_ctrl;
  import useq_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmdRun, cmdHalt, cmdStep, brkEn;
  logic [15:0] stepCnt;
  uAddr_t      brkAddr, uAddr;

  int testsRun    = 0;
  int testsFailed = 0;
  int pulses1     = 0;   // every clken pulse seen on dut1, including reset
  int pulses3     = 0;

  always #5 clk = ~clk;

  useq_run_ctrl_if #(.CNTW(36)) if1 ();
  useq_run_ctrl_if #(.CNTW(36)) if3 ();

  assign if1.cmdRUN  = cmdRun;   assign if3.cmdRUN  = cmdRun;
  assign if1.cmdHALT = cmdHalt;  assign if3.cmdHALT = cmdHalt;
  assign if1.cmdSTEP = cmdStep;  assign if3.cmdSTEP = cmdStep;
  assign if1.stepCNT = stepCnt;  assign if3.stepCNT = stepCnt;
  assign if1.brkEN   = brkEn;    assign if3.brkEN   = brkEn;
  assign if1.brkADDR = brkAddr;  assign if3.brkADDR = brkAddr;
  assign if1.uADDR   = uAddr;    assign if3.uADDR   = uAddr;

  useq_run_ctrl #(.RST_CYCLES(4), .CLKDIV(1), .CNTW(36)) dut1 (
    .clk (clk), .rst (rst), .bus (if1)
  );

  useq_run_ctrl #(.RST_CYCLES(4), .CLKDIV(3), .CNTW(36)) dut3 (
    .clk (clk), .rst (rst), .bus (if3)
  );

  always @(posedge clk) begin
    if (if1.clken) pulses1++;
    if (if3.clken) pulses3++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One-cycle command pulse, returns at the falling edge where it drops.
  task automatic issue(input logic run, input logic halt, input logic step, input logic [15:0] cnt);
    @(negedge clk);
    cmdRun = run; cmdHalt = halt; cmdStep = step; stepCnt = cnt;
    @(negedge clk);
    cmdRun = 1'b0; cmdHalt = 1'b0; cmdStep = 1'b0;
  endtask

  // Counts cycles of cpuRST&clken after rst release; optionally fires a
  // cmdRUN into the RESET window, which must be dropped.
  task automatic resetSeq(input string tag, input logic sendCmd);
    int n1 = 0;
    int n3 = 0;
    int snap;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (if1.cpuRST && if1.clken) n1++;
      if (if3.cpuRST && if3.clken) n3++;
      if (sendCmd && i == 1) cmdRun = 1'b1;
      if (i == 2) cmdRun = 1'b0;
    end
    check({tag, "_rstcyc1"}, 64'(n1), 64'd4);
    check({tag, "_rstcyc3"}, 64'(n3), 64'd4);
    check({tag, "_cpuRST"},  64'(if1.cpuRST), 64'd0);
    check({tag, "_halted"},  64'(if1.halted), 64'd1);
    check({tag, "_cyc"},     64'(if1.cycCOUNT), 64'd0);
    check({tag, "_clken"},   64'(if1.clken), 64'd0);
    check({tag, "_brkHIT"},  64'(if1.brkHIT), 64'd0);
    snap = pulses1;
    repeat (5) @(negedge clk);
    check({tag, "_idle"},    64'(pulses1 - snap), 64'd0);
  endtask

  initial begin
    int n1, n3, first1, last1, first3, last3, gapBad;

    rst = 1'b1; cmdRun = 1'b0; cmdHalt = 1'b0; cmdStep = 1'b0;
    stepCnt = 16'd0; brkEn = 1'b0; brkAddr = '0; uAddr = PAGE_FAIL_ADDR;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("inrst_cpuRST", 64'(if1.cpuRST), 64'd1);
    check("inrst_clken",  64'(if1.clken),  64'd0);
    check("inrst_halted", 64'(if1.halted), 64'd0);
    check("inrst_cyc",    64'(if1.cycCOUNT), 64'd0);
    rst = 1'b1;
    resetSeq("por", 1'b0);

    // Step 3 at CLKDIV=1: three back-to-back pulses, then HALT.
    issue(1'b0, 1'b0, 1'b1, 16'd3);
    n1 = 0; n3 = 0; first1 = -1; last1 = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (if1.clken) begin
        if (first1 < 0) first1 = i;
        last1 = i;
        n1++;
      end
      if (if3.clken) n3++;
    end
    check("step3_n1",     64'(n1), 64'd3);
    check("step3_first1", 64'(first1), 64'd0);
    check("step3_span1",  64'(last1 - first1), 64'd2);
    check("step3_n3",     64'(n3), 64'd3);
    check("step3_halted", 64'(if1.halted), 64'd1);
    check("step3_cyc1",   64'(if1.cycCOUNT), 64'd3);
    check("step3_cyc3",   64'(if3.cycCOUNT), 64'd3);

    // stepCNT = 0 behaves as 1.
    issue(1'b0, 1'b0, 1'b1, 16'd0);
    n1 = 0; n3 = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (if1.clken) n1++;
      if (if3.clken) n3++;
    end
    check("step0_n1",   64'(n1), 64'd1);
    check("step0_n3",   64'(n3), 64'd1);
    check("step0_cyc1", 64'(if1.cycCOUNT), 64'd4);

    // Free run at CLKDIV=3: pulses at samples 2,5,8,11 after entry.
    issue(1'b1, 1'b0, 1'b0, 16'd0);
    n3 = 0; first3 = -1; last3 = -1; gapBad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (if3.clken) begin
        if (last3 >= 0 && i - last3 != 3) gapBad++;
        if (first3 < 0) first3 = i;
        last3 = i;
        n3++;
      end
    end
    check("run_n3",     64'(n3), 64'd4);
    check("run_first3", 64'(first3), 64'd2);
    check("run_gap3",   64'(gapBad), 64'd0);
    check("run_going1", 64'(if1.halted), 64'd0);
    issue(1'b0, 1'b1, 1'b0, 16'd0);
    n1 = 0; n3 = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (if1.clken) n1++;
      if (if3.clken) n3++;
    end
    check("halt_post1",  64'(n1), 64'd0);
    check("halt_post3",  64'(n3), 64'd0);
    check("halt_halted", 64'(if3.halted), 64'd1);
    check("halt_cyc3",   64'(if3.cycCOUNT), 64'(pulses3 - 4));
    check("halt_cyc3v",  64'(if3.cycCOUNT), 64'd8);
    check("halt_cyc1",   64'(if1.cycCOUNT), 64'(pulses1 - 4));

    // Breakpoint at o0100 while running on dut1.
    brkEn = 1'b1; brkAddr = 12'o0100; uAddr = 12'o0076;
    issue(1'b1, 1'b0, 1'b0, 16'd0);
    n1 = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (if1.clken) n1++;
    end
    check("brk_pre_n1",  64'(n1), 64'd4);
    uAddr = 12'o0100;
    n1 = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (if1.clken) n1++;
    end
    check("brk_supp_n1", 64'(n1), 64'd0);
    check("brk_halted",  64'(if1.halted), 64'd1);
    check("brk_hit",     64'(if1.brkHIT), 64'd1);
    check("brk_cyc1",    64'(if1.cycCOUNT), 64'(pulses1 - 4));

    // Resume with a single step at the breakpoint address: it must advance.
    issue(1'b0, 1'b0, 1'b1, 16'd1);
    n1 = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (if1.clken) n1++;
    end
    check("brkstep_n1",     64'(n1), 64'd1);
    check("brkstep_hit",    64'(if1.brkHIT), 64'd0);
    check("brkstep_halted", 64'(if1.halted), 64'd1);

    // Same-cycle command priority.
    brkEn = 1'b0;
    issue(1'b1, 1'b1, 1'b0, 16'd0);
    n1 = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (if1.clken) n1++;
    end
    check("prio_haltrun_n1", 64'(n1), 64'd0);
    check("prio_haltrun_h",  64'(if1.halted), 64'd1);
    issue(1'b1, 1'b0, 1'b1, 16'd2);
    n1 = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (if1.clken) n1++;
    end
    check("prio_steprun_n1", 64'(n1), 64'd2);
    check("prio_steprun_h",  64'(if1.halted), 64'd1);

    // Asynchronous reset in the middle of a run.
    issue(1'b1, 1'b0, 1'b0, 16'd0);
    repeat (3) @(negedge clk);
    check("mid_running", 64'(if1.halted), 64'd0);
    #2 rst = 1'b0;
    #1;
    check("mid_clken",  64'(if1.clken), 64'd0);
    check("mid_cpuRST", 64'(if1.cpuRST), 64'd1);
    check("mid_cyc",    64'(if1.cycCOUNT), 64'd0);
    check("mid_brkHIT", 64'(if1.brkHIT), 64'd0);
    check("mid_halted", 64'(if1.halted), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    resetSeq("rerst", 1'b1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
